// File: rtl/regbank_pkg.sv
// Shared widths, requester identifiers and the FIFO entry type for the
// register-bank write arbiter.
package regbank_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 2 ** ADDR_W;

    localparam bit REQ_ALU = 1'b0;
    localparam bit REQ_MEM = 1'b1;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } wr_entry_t;
endpackage

// File: rtl/regbank_write_arbiter_if.sv
// Valid/ready write-request handshakes from the ALU (req0) and
// load (req1) writeback paths.
interface regbank_write_arbiter_if;
    import regbank_pkg::*;

    logic      req0_valid;
    reg_addr_t req0_addr;
    reg_data_t req0_data;
    logic      req0_ready;

    logic      req1_valid;
    reg_addr_t req1_addr;
    reg_data_t req1_data;
    logic      req1_ready;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/regwr_fifo.sv
// Small synchronous FIFO of {addr,data} write entries with full/empty flags.
// The caller never pushes when full nor pops when empty.
module regwr_fifo
    import regbank_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      srst,
    input  logic      push,
    input  wr_entry_t push_entry,
    input  logic      pop,
    output wr_entry_t head,
    output logic      full,
    output logic      empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wr_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign head  = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter sharing the register-bank write port between ALU and
// load writeback, with a per-register pending-write scoreboard for decode stall.
module regbank_write_arbiter
    import regbank_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    regbank_write_arbiter_if.slave   req,
    input  logic                     rd_check,
    input  reg_addr_t                rs,
    input  reg_addr_t                rt,
    output logic                     stall,
    output logic                     RegWrite,
    output reg_addr_t                rd,
    output reg_data_t                dataToWrite
);
    localparam int PEND_W = $clog2(2 * FIFO_DEPTH + 1);

    logic [NREGS-1:0][PEND_W-1:0] pend_all;
    logic [NREGS-1:0]             owner_all;

    logic      full0, empty0, full1, empty1;
    wr_entry_t head0, head1;
    wr_entry_t push_entry0, push_entry1;
    logic      ready0, ready1, conflict;
    logic      accept0, accept1;
    logic      pop0, pop1, pop_valid;
    wr_entry_t pop_entry;

    logic      last_grant_reg;
    logic      regwrite_reg;
    reg_addr_t rd_reg;
    reg_data_t data_reg;

    // A register already pending is only open to the requester that owns it,
    // which keeps per-register write order equal to acceptance order.
    assign ready0   = !full0 &&
                      ((pend_all[req.req0_addr] == '0) || (owner_all[req.req0_addr] == REQ_ALU));
    assign conflict = req.req0_valid && ready0 && (req.req0_addr == req.req1_addr);
    assign ready1   = !full1 && !conflict &&
                      ((pend_all[req.req1_addr] == '0) || (owner_all[req.req1_addr] == REQ_MEM));

    assign req.req0_ready = ready0;
    assign req.req1_ready = ready1;

    assign accept0 = req.req0_valid && ready0 && !reset;
    assign accept1 = req.req1_valid && ready1 && !reset;

    assign push_entry0 = '{addr: req.req0_addr, data: req.req0_data};
    assign push_entry1 = '{addr: req.req1_addr, data: req.req1_data};

    regwr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk        (clock),
        .srst       (reset),
        .push       (accept0),
        .push_entry (push_entry0),
        .pop        (pop0),
        .head       (head0),
        .full       (full0),
        .empty      (empty0)
    );

    regwr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk        (clock),
        .srst       (reset),
        .push       (accept1),
        .push_entry (push_entry1),
        .pop        (pop1),
        .head       (head1),
        .full       (full1),
        .empty      (empty1)
    );

    always_comb begin
        pop0 = 1'b0;
        pop1 = 1'b0;
        if (!reset) begin
            if (!empty0 && !empty1) begin
                if (last_grant_reg == REQ_ALU) begin
                    pop1 = 1'b1;
                end else begin
                    pop0 = 1'b1;
                end
            end else if (!empty0) begin
                pop0 = 1'b1;
            end else if (!empty1) begin
                pop1 = 1'b1;
            end
        end
    end

    assign pop_valid = pop0 || pop1;
    assign pop_entry = pop1 ? head1 : head0;

    always_ff @(posedge clock) begin
        if (reset) begin
            regwrite_reg   <= 1'b0;
            rd_reg         <= '0;
            data_reg       <= '0;
            last_grant_reg <= REQ_MEM;
        end else begin
            regwrite_reg <= pop_valid;
            if (pop_valid) begin
                rd_reg         <= pop_entry.addr;
                data_reg       <= pop_entry.data;
                last_grant_reg <= pop1 ? REQ_MEM : REQ_ALU;
            end
        end
    end

    assign RegWrite    = regwrite_reg;
    assign rd          = rd_reg;
    assign dataToWrite = data_reg;

    // Pending count drops on the edge that raises RegWrite, so stall is
    // already low during the strobe cycle.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_sb
        logic              inc0, inc1, dec;
        logic [PEND_W-1:0] pend_reg;
        logic              owner_reg;

        assign inc0 = accept0 && (req.req0_addr == reg_addr_t'(gi));
        assign inc1 = accept1 && (req.req1_addr == reg_addr_t'(gi));
        assign dec  = pop_valid && (pop_entry.addr == reg_addr_t'(gi));

        always_ff @(posedge clock) begin
            if (reset) begin
                pend_reg  <= '0;
                owner_reg <= REQ_ALU;
            end else begin
                case ({inc0 || inc1, dec})
                    2'b10:   pend_reg <= pend_reg + 1'b1;
                    2'b01:   pend_reg <= pend_reg - 1'b1;
                    default: pend_reg <= pend_reg;
                endcase
                if (inc1) begin
                    owner_reg <= REQ_MEM;
                end else if (inc0) begin
                    owner_reg <= REQ_ALU;
                end
            end
        end

        assign pend_all[gi]  = pend_reg;
        assign owner_all[gi] = owner_reg;
    end

    assign stall = rd_check && ((pend_all[rs] != '0) || (pend_all[rt] != '0));
endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed bench for regbank_write_arbiter: per-requester model FIFOs and a
// round-robin model feed an expected-commit queue checked against RegWrite.
module tb_regbank_write_arbiter;
    import regbank_pkg::*;

    logic      clock = 1'b0;
    logic      reset;
    logic      rd_check;
    reg_addr_t rs, rt;
    logic      stall;
    logic      RegWrite;
    reg_addr_t rd;
    reg_data_t dataToWrite;

    regbank_write_arbiter_if bus ();

    regbank_write_arbiter #(.FIFO_DEPTH(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (bus),
        .rd_check    (rd_check),
        .rs          (rs),
        .rt          (rt),
        .stall       (stall),
        .RegWrite    (RegWrite),
        .rd          (rd),
        .dataToWrite (dataToWrite)
    );

    always #5 clock = ~clock;

    int        tests = 0;
    int        fails = 0;
    wr_entry_t mf0[$];
    wr_entry_t mf1[$];
    wr_entry_t exp_q[$];
    logic      mlast = REQ_MEM;
    int        cnt_r1 = 0;
    int        cnt_r2 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Called just after a negedge with inputs set; advances one clock and
    // checks the write port at the following negedge.
    task automatic step();
        logic      acc0, acc1, popped;
        wr_entry_t e;
        #1;
        acc0   = bus.req0_valid && bus.req0_ready;
        acc1   = bus.req1_valid && bus.req1_ready;
        popped = 1'b0;
        e      = '0;
        if (reset) begin
            mf0.delete();
            mf1.delete();
            exp_q.delete();
            mlast = REQ_MEM;
        end else begin
            if (mf0.size() > 0 && mf1.size() > 0) begin
                if (mlast == REQ_ALU) begin
                    e = mf1.pop_front();
                    mlast = REQ_MEM;
                end else begin
                    e = mf0.pop_front();
                    mlast = REQ_ALU;
                end
                popped = 1'b1;
            end else if (mf0.size() > 0) begin
                e = mf0.pop_front();
                mlast = REQ_ALU;
                popped = 1'b1;
            end else if (mf1.size() > 0) begin
                e = mf1.pop_front();
                mlast = REQ_MEM;
                popped = 1'b1;
            end
            if (popped) exp_q.push_back(e);
            if (acc0) mf0.push_back('{addr: bus.req0_addr, data: bus.req0_data});
            if (acc1) mf1.push_back('{addr: bus.req1_addr, data: bus.req1_data});
        end
        @(posedge clock);
        @(negedge clock);
        chk("regwrite", 32'(RegWrite), 32'(popped));
        if (RegWrite === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rd", 32'(rd), 32'(e.addr));
            chk("data", 32'(dataToWrite), 32'(e.data));
            $display("[TB] commit rd=%0d data=%h", rd, dataToWrite);
            if (rd == 3'd1) cnt_r1++;
            if (rd == 3'd2) cnt_r2++;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 10; k++) begin
            if (mf0.size() > 0 || mf1.size() > 0) step();
        end
        chk("drained", 32'(mf0.size() + mf1.size()), 32'd0);
    endtask

    initial begin
        // Reset with both requesters valid: ready high, nothing accepted.
        reset = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_addr = 3'd1; bus.req0_data = 16'h0011;
        bus.req1_valid = 1'b1; bus.req1_addr = 3'd2; bus.req1_data = 16'h0022;
        rd_check = 1'b1; rs = 3'd1; rt = 3'd2;
        step();
        step();
        #1;
        chk("rst_ready0", 32'(bus.req0_ready), 32'd1);
        chk("rst_ready1", 32'(bus.req1_ready), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_data", 32'(dataToWrite), 32'd0);
        reset = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        step();
        chk("post_rst_stall", 32'(stall), 32'd0);

        // Single ALU write, stall window on r3.
        bus.req0_valid = 1'b1; bus.req0_addr = 3'd3; bus.req0_data = 16'h1234;
        rs = 3'd3; rt = 3'd0;
        #1 chk("t2_ready0", 32'(bus.req0_ready), 32'd1);
        step();
        bus.req0_valid = 1'b0;
        #1 chk("t2_stall_pending", 32'(stall), 32'd1);
        step();
        #1 chk("t2_stall_clear", 32'(stall), 32'd0);

        // Both requesters every cycle on distinct registers.
        rd_check = 1'b0;
        cnt_r1 = 0; cnt_r2 = 0;
        for (int i = 0; i < 20; i++) begin
            bus.req0_valid = 1'b1; bus.req0_addr = 3'd1; bus.req0_data = 16'h0100 + 16'(i);
            bus.req1_valid = 1'b1; bus.req1_addr = 3'd2; bus.req1_data = 16'h0200 + 16'(i);
            step();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        drain();
        chk("t3_alu_served", 32'(cnt_r1 >= 8), 32'd1);
        chk("t3_mem_served", 32'(cnt_r2 >= 8), 32'd1);

        // Same-register conflict: ALU wins, load follows in order.
        bus.req0_valid = 1'b1; bus.req0_addr = 3'd5; bus.req0_data = 16'hAAAA;
        bus.req1_valid = 1'b1; bus.req1_addr = 3'd5; bus.req1_data = 16'hBBBB;
        #1;
        chk("t4_ready0", 32'(bus.req0_ready), 32'd1);
        chk("t4_ready1_conflict", 32'(bus.req1_ready), 32'd0);
        step();
        bus.req0_valid = 1'b0;
        #1 chk("t4_ready1_owned", 32'(bus.req1_ready), 32'd0);
        step();
        #1 chk("t4_ready1_free", 32'(bus.req1_ready), 32'd1);
        step();
        bus.req1_valid = 1'b0;
        step();

        // FIFO0 fill: set last grant to ALU, then the load FIFO takes the first pop.
        bus.req0_valid = 1'b1; bus.req0_addr = 3'd4; bus.req0_data = 16'h4444;
        step();
        bus.req0_valid = 1'b0;
        step();
        bus.req0_valid = 1'b1; bus.req0_addr = 3'd6; bus.req0_data = 16'h6001;
        bus.req1_valid = 1'b1; bus.req1_addr = 3'd7; bus.req1_data = 16'h7001;
        #1 chk("t5_ready0_push1", 32'(bus.req0_ready), 32'd1);
        step();
        bus.req0_data = 16'h6002; bus.req1_data = 16'h7002;
        #1 chk("t5_ready0_push2", 32'(bus.req0_ready), 32'd1);
        step();
        bus.req1_valid = 1'b0;
        bus.req0_data = 16'h6003;
        #1 chk("t5_ready0_full", 32'(bus.req0_ready), 32'd0);
        step();
        #1 chk("t5_ready0_freed", 32'(bus.req0_ready), 32'd1);
        step();
        bus.req0_valid = 1'b0;
        drain();

        // Reset with two buffered writes: they are discarded.
        bus.req0_valid = 1'b1; bus.req0_addr = 3'd1; bus.req0_data = 16'h1111;
        bus.req1_valid = 1'b1; bus.req1_addr = 3'd2; bus.req1_data = 16'h2222;
        rd_check = 1'b1; rs = 3'd1; rt = 3'd2;
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1 chk("t6_stall_before", 32'(stall), 32'd1);
        reset = 1'b1;
        step();
        chk("t6_rd", 32'(rd), 32'd0);
        chk("t6_data", 32'(dataToWrite), 32'd0);
        for (int i = 0; i < NREGS; i++) begin
            rs = reg_addr_t'(i);
            rt = reg_addr_t'(NREGS - 1 - i);
            #1 chk("t6_stall_cleared", 32'(stall), 32'd0);
        end
        reset = 1'b0;
        step();
        step();
        chk("t6_exp_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
